// File: rtl/s_tx_ctrl.sv
// s_tx_ctrl: transmit frame sequencer feeding the TX byte connector.
// A frame is i_len SDP bytes followed by one CRC-8 byte, then a fixed idle gap.
// The CRC-8 is accumulated over SDP bytes as the serializer accepts them.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst       synchronous reset, active-high
//   i_start     1-cycle frame request, only honoured in IDLE
//   i_len       SDP byte count, latched on an accepted start
//   i_sdp_rdy   SDP source holds a valid byte on i_sdp_byte
//   i_sdp_byte  current SDP byte
//   i_ser_ack   serializer accepted the byte offered this cycle
//   o_tx_state  one-hot {SENDING_CRC, SENDING_SDP}, 2'b00 otherwise (registered)
//   o_crc_rdy   CRC byte valid (registered)
//   o_crc_byte  CRC value (registered)
//   o_sdp_pop   advance SDP source (combinational)
//   o_busy      high in every state except IDLE (registered)
//   o_done      1-cycle pulse in the last GAP cycle (registered)
module s_tx_ctrl #(
   parameter int unsigned LEN_W    = 4,
   parameter logic [7:0]  CRC_POLY = 8'h07,
   parameter logic [7:0]  CRC_INIT = 8'h00,
   parameter int unsigned GAP_CYC  = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_sdp_rdy,
   input  logic [7:0]       i_sdp_byte,
   input  logic             i_ser_ack,
   output logic [1:0]       o_tx_state,
   output logic             o_crc_rdy,
   output logic [7:0]       o_crc_byte,
   output logic             o_sdp_pop,
   output logic             o_busy,
   output logic             o_done
);

   localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GapW-1:0] GapMax = GapW'(GAP_CYC - 1);

   typedef enum logic [1:0] {StIdle, StSdp, StCrc, StGap} state_t;

   state_t           r_state, w_state_d;
   logic [LEN_W-1:0] r_len, w_len_d;
   logic [LEN_W-1:0] r_byte_cnt, w_byte_cnt_d;
   logic [GapW-1:0]  r_gap_cnt, w_gap_cnt_d;
   logic [7:0]       r_crc, w_crc_d;
   logic [1:0]       r_tx_state, w_tx_state_d;
   logic             r_crc_rdy, r_busy, r_done;
   logic             w_done_d;
   logic             w_xfer;
   // One bit wider than the counter so len = 2**LEN_W-1 compares without wrapping.
   logic [LEN_W:0]   w_cnt_inc;

   // MSB-first CRC-8 over one byte, no reflection, no final XOR.
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
      logic [7:0] c;
      logic       fb;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         fb = c[7] ^ d[i];
         c  = {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
      end
      return c;
   endfunction

   // r_tx_state[0] is set exactly while in SDP.
   assign w_xfer    = i_sdp_rdy & i_ser_ack & r_tx_state[0];
   assign w_cnt_inc = (LEN_W+1)'(r_byte_cnt) + (LEN_W+1)'(1);

   always_comb begin
      w_state_d    = r_state;
      w_len_d      = r_len;
      w_byte_cnt_d = r_byte_cnt;
      w_gap_cnt_d  = r_gap_cnt;
      w_crc_d      = r_crc;
      case (r_state)
         StIdle: begin
            if (i_start) begin
               w_len_d      = i_len;
               w_crc_d      = CRC_INIT;
               w_byte_cnt_d = '0;
               w_state_d    = (i_len == '0) ? StCrc : StSdp;
            end
         end
         StSdp: begin
            if (w_xfer) begin
               w_crc_d = crc8_byte(r_crc, i_sdp_byte);
               if (w_cnt_inc == {1'b0, r_len}) begin
                  w_byte_cnt_d = '0;
                  w_state_d    = StCrc;
               end else begin
                  w_byte_cnt_d = w_cnt_inc[LEN_W-1:0];
               end
            end
         end
         StCrc: begin
            if (i_ser_ack) begin
               w_gap_cnt_d = '0;
               w_state_d   = StGap;
            end
         end
         StGap: begin
            if (r_gap_cnt == GapMax) begin
               w_gap_cnt_d = '0;
               w_state_d   = StIdle;
            end else begin
               w_gap_cnt_d = r_gap_cnt + GapW'(1);
            end
         end
         default: w_state_d = StIdle;
      endcase

      w_tx_state_d = {w_state_d == StCrc, w_state_d == StSdp};
      // done is raised for the final GAP cycle, so a start coinciding with it is still seen as busy.
      w_done_d     = (w_state_d == StGap) && (w_gap_cnt_d == GapMax);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= StIdle;
         r_len      <= '0;
         r_byte_cnt <= '0;
         r_gap_cnt  <= '0;
         r_crc      <= CRC_INIT;
         r_tx_state <= 2'b00;
         r_crc_rdy  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_len      <= w_len_d;
         r_byte_cnt <= w_byte_cnt_d;
         r_gap_cnt  <= w_gap_cnt_d;
         r_crc      <= w_crc_d;
         r_tx_state <= w_tx_state_d;
         r_crc_rdy  <= (w_state_d == StCrc);
         r_busy     <= (w_state_d != StIdle);
         r_done     <= w_done_d;
      end
   end

   assign o_tx_state = r_tx_state;
   assign o_crc_rdy  = r_crc_rdy;
   assign o_crc_byte = r_crc;
   assign o_sdp_pop  = w_xfer;
   assign o_busy     = r_busy;
   assign o_done     = r_done;

endmodule

// File: tb/tb_s_tx_ctrl.sv
// Testbench for s_tx_ctrl: directed frames with a CRC scoreboard.
module tb_s_tx_ctrl;

   localparam int unsigned GapCyc = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] len = 4'd0;
   logic       sdp_rdy = 1'b0;
   logic [7:0] sdp_byte = 8'h00;
   logic       ser_ack = 1'b0;
   logic [1:0] tx_state;
   logic       crc_rdy;
   logic [7:0] crc_byte;
   logic       sdp_pop;
   logic       busy;
   logic       done;

   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   logic [7:0] data[16];
   logic [7:0] last_crc;

   s_tx_ctrl #(
      .LEN_W   (4),
      .CRC_POLY(8'h07),
      .CRC_INIT(8'h00),
      .GAP_CYC (GapCyc)
   ) u_dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start),
      .i_len     (len),
      .i_sdp_rdy (sdp_rdy),
      .i_sdp_byte(sdp_byte),
      .i_ser_ack (ser_ack),
      .o_tx_state(tx_state),
      .o_crc_rdy (crc_rdy),
      .o_crc_byte(crc_byte),
      .o_sdp_pop (sdp_pop),
      .o_busy    (busy),
      .o_done    (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Table-free CRC-8 reference in the xor-then-shift form.
   function automatic logic [7:0] ref_crc(input int n);
      logic [7:0] c;
      c = 8'h00;
      for (int i = 0; i < n; i++) begin
         c = c ^ data[i];
         for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   task automatic check_idle(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         start = 1'b0;
         sdp_rdy = 1'b0;
         ser_ack = 1'b0;
         #1;
         check({tag, "_idle_busy"}, 32'(busy), 32'd0);
         check({tag, "_idle_done"}, 32'(done), 32'd0);
         check({tag, "_idle_tx"}, 32'(tx_state), 32'd0);
      end
   endtask

   // One frame of n bytes from data[]; rnd throttles rdy/ack, poke pulses start while busy.
   task automatic run_frame(input int n, input bit rnd, input bit poke, input string tag);
      int         idx = 0;
      int         pops = 0;
      int         sdp_cyc = 0;
      int         gap_cyc = 0;
      bit         crc_seen = 0;
      bit         acked = 0;
      bit         got_done = 0;
      logic [7:0] held = 8'h00;
      exp_q.push_back(ref_crc(n));
      @(negedge clk);
      start = 1'b1;
      len = n[3:0];
      for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         sdp_rdy = rnd ? ($urandom_range(3) != 0) : 1'b1;
         ser_ack = rnd ? 1'($urandom_range(1)) : 1'b1;
         sdp_byte = data[idx[3:0]];
         #1;
         check({tag, "_onehot"}, 32'(tx_state == 2'b11), 32'd0);
         check({tag, "_pop"}, 32'(sdp_pop), 32'(sdp_rdy & ser_ack & (tx_state == 2'b01)));
         if (tx_state == 2'b01) begin
            sdp_cyc++;
            if (sdp_pop) begin
               idx++;
               pops++;
            end
         end
         if (tx_state == 2'b10) begin
            check({tag, "_crc_rdy"}, 32'(crc_rdy), 32'd1);
            if (crc_seen) check({tag, "_crc_stable"}, 32'(crc_byte), 32'(held));
            else begin
               held = crc_byte;
               crc_seen = 1;
            end
            if (ser_ack) begin
               acked = 1;
               last_crc = crc_byte;
               check({tag, "_q_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) check({tag, "_crc"}, 32'(crc_byte), 32'(exp_q.pop_front()));
            end
         end else if (acked) begin
            gap_cyc++;
            check({tag, "_gap_rdy"}, 32'(crc_rdy), 32'd0);
            check({tag, "_gap_busy"}, 32'(busy), 32'd1);
            check({tag, "_gap_tx"}, 32'(tx_state), 32'd0);
            if (done) got_done = 1;
         end
         if (poke && busy) begin
            start = 1'b1;
            len = 4'd2;
         end
      end
      check({tag, "_done_seen"}, 32'(got_done), 32'd1);
      check({tag, "_pops"}, 32'(pops), 32'(n));
      check({tag, "_crc_seen"}, 32'(crc_seen), 32'd1);
      check({tag, "_gap_cyc"}, 32'(gap_cyc), 32'(GapCyc));
      if (!rnd) check({tag, "_sdp_cyc"}, 32'(sdp_cyc), 32'(n));
      check_idle(tag, 3);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_tx", 32'(tx_state), 32'd0);
      check("rst_crc_rdy", 32'(crc_rdy), 32'd0);
      check("rst_crc_byte", 32'(crc_byte), 32'h00);
      check("rst_pop", 32'(sdp_pop), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;

      // "123456789" check vector
      for (int i = 0; i < 9; i++) data[i] = 8'h31 + 8'(i);
      run_frame(9, 0, 0, "t1");
      check("t1_vec", 32'(last_crc), 32'hF4);

      data[0] = 8'h01;
      run_frame(1, 0, 0, "t2a");
      check("t2a_vec", 32'(last_crc), 32'h07);
      data[0] = 8'h00;
      run_frame(1, 0, 0, "t2b");
      check("t2b_vec", 32'(last_crc), 32'h00);

      run_frame(0, 0, 0, "t3");
      check("t3_vec", 32'(last_crc), 32'h00);

      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 3; i++) data[i] = 8'($urandom);
         run_frame(3, 1, 0, "t4");
      end

      // Abort on the second SDP byte of a len=5 frame.
      for (int i = 0; i < 5; i++) data[i] = 8'hA0 + 8'(i);
      @(negedge clk);
      start = 1'b1;
      len = 4'd5;
      @(negedge clk);
      start = 1'b0;
      sdp_rdy = 1'b1;
      ser_ack = 1'b1;
      sdp_byte = data[0];
      @(negedge clk);
      sdp_byte = data[1];
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("t5_tx", 32'(tx_state), 32'd0);
      check("t5_crc_rdy", 32'(crc_rdy), 32'd0);
      check("t5_crc_byte", 32'(crc_byte), 32'h00);
      check("t5_pop", 32'(sdp_pop), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      rst = 1'b0;
      check_idle("t5", 6);
      data[0] = 8'h01;
      run_frame(1, 0, 0, "t5b");
      check("t5b_vec", 32'(last_crc), 32'h07);

      for (int i = 0; i < 4; i++) data[i] = 8'h5A ^ 8'(i * 17);
      run_frame(4, 0, 1, "t6");
      check("t6_q_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
